// File: rtl/motor_pkg.sv
// Shared motor-control definitions: phase-state encoding, command bit positions
// and the dead-time counter width used by the gate_deadtime block.
package motor_pkg;

  localparam int CNT_W  = 8;
  localparam int CMD_EN = 0;
  localparam int CMD_HI = 1;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_HI_ON = 2'd1;
  localparam logic [1:0] ST_LO_ON = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  // Maps a 2-bit phase command onto the state it asks the phase to reach.
  function automatic logic [1:0] cmd_to_state(input logic [1:0] cmd);
    logic [1:0] st;
    if (!cmd[CMD_EN]) begin
      st = ST_OFF;
    end else if (cmd[CMD_HI]) begin
      st = ST_HI_ON;
    end else begin
      st = ST_LO_ON;
    end
    return st;
  endfunction

endpackage

// File: rtl/gate_deadtime_phase.sv
// One inverter leg: request decode, OFF/HI_ON/LO_ON/DEAD state machine,
// 8-bit dead counter and registered high/low gate enables.
module gate_deadtime_phase
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_cmd,
  input  logic       i_force,
  output logic       o_gate_h,
  output logic       o_gate_l
);

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gate_h;
  logic             r_gate_l;

  logic [1:0]       w_req;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_req = cmd_to_state(i_cmd);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_force) begin
      w_state_nxt = ST_DEAD;
      w_cnt_nxt   = DEAD_LOAD;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = w_req;
        end
        ST_HI_ON, ST_LO_ON: begin
          // Any change, including turn-off, goes through a full dead interval.
          if (w_req != r_state) begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = DEAD_LOAD;
          end
        end
        default: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_state_nxt = w_req;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_DEAD;
      r_cnt    <= DEAD_LOAD;
      r_gate_h <= 1'b0;
      r_gate_l <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gate_h <= (w_state_nxt == ST_HI_ON);
      r_gate_l <= (w_state_nxt == ST_LO_ON);
    end
  end

  assign o_gate_h = r_gate_h;
  assign o_gate_l = r_gate_l;

endmodule

// File: rtl/gate_deadtime.sv
// Three-phase gate-drive conditioner with guaranteed both-off dead time.
// Optional trip input and sticky fault latch are built when DEADTIME_FAULT_EN is defined.
module gate_deadtime
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
`ifdef DEADTIME_FAULT_EN
  input  logic       FAULT,
  input  logic       FAULT_CLR,
  output logic       FAULT_LATCHED,
`endif
  output logic [2:0] GATE_H,
  output logic [2:0] GATE_L
);

  logic [2:0][1:0] r_cmd;
  logic            w_force;

  // Commands arrive from another clock domain; register them before decode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cmd <= '0;
    end else begin
      r_cmd <= {C, B, A};
    end
  end

`ifdef DEADTIME_FAULT_EN
  logic r_fault_meta;
  logic r_fault_sync;
  logic r_fault_latched;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fault_meta    <= 1'b0;
      r_fault_sync    <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_fault_meta <= FAULT;
      r_fault_sync <= r_fault_meta;
      // A live trip overrides a simultaneous clear.
      if (r_fault_sync) begin
        r_fault_latched <= 1'b1;
      end else if (FAULT_CLR) begin
        r_fault_latched <= 1'b0;
      end
    end
  end

  assign w_force       = r_fault_sync | r_fault_latched;
  assign FAULT_LATCHED = r_fault_latched;
`else
  assign w_force = 1'b0;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_phase
    gate_deadtime_phase #(
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_phase (
      .clk      (CLK),
      .rst_n    (RST),
      .i_cmd    (r_cmd[g]),
      .i_force  (w_force),
      .o_gate_h (GATE_H[g]),
      .o_gate_l (GATE_L[g])
    );
  end

endmodule
